apu_mixer_dac: RTL and testbench

Output-end consumer for the APU channel blocks. It samples the four 9-bit channel outputs on a sample-rate strobe, mutes any selected channels, and sums them with a time-multiplexed accumulator into an 11-bit mixed sample. It then drives that sample out as a 1-bit first-order sigma-delta (PDM) stream for an external RC filter. It sits between the four channel blocks and the board audio pin.

---
 rtl/apu_mixer_dac_if.sv | 26 ++
 rtl/apu_mixer_dac.sv | 114 +++++++++++
 tb/tb_apu_mixer_dac.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apu_mixer_dac_if.sv
// Mixer bus: channel sample inputs, sample strobe and mute mask in,
// mixed sample, status pulses and PDM bitstream out.
interface apu_mixer_dac_if;
  logic       i_sample_stb;
  logic [8:0] i_ch1;
  logic [8:0] i_ch2;
  logic [8:0] i_ch3;
  logic [8:0] i_ch4;
  logic [3:0] i_mute;
  logic [10:0] o_sample;
  logic       o_sample_valid;
  logic       o_overrun;
  logic       o_pdm;

  // Channel/strobe source side (APU core or bench).
  modport master (
    output i_sample_stb, i_ch1, i_ch2, i_ch3, i_ch4, i_mute,
    input  o_sample, o_sample_valid, o_overrun, o_pdm
  );

  // Mixer side.
  modport slave (
    input  i_sample_stb, i_ch1, i_ch2, i_ch3, i_ch4, i_mute,
    output o_sample, o_sample_valid, o_overrun, o_pdm
  );
endinterface

// File: rtl/apu_mixer_dac.sv
// APU output mixer: snapshots four 9-bit channels on a strobe, applies the
// mute mask, sums them one channel per cycle into an 11-bit sample, and
// emits that sample as a first-order sigma-delta bitstream.
module apu_mixer_dac (
  input  logic            i_clk,
  input  logic            i_rst_n,
  apu_mixer_dac_if.slave  bus
);
  localparam int NUM_CH = 4;
  localparam int CH_W   = 9;
  localparam int MIX_W  = 11;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                          r_state, w_state_nxt;
  logic [NUM_CH-1:0][CH_W-1:0]     w_ch, w_cap, r_hold;
  logic [1:0]                      r_idx;
  logic [MIX_W-1:0]                r_acc, r_sample, r_sd;
  logic                            r_valid, r_pdm;
  logic                            w_capture, w_add, w_done, w_overrun;
  logic [MIX_W:0]                  w_sd_sum;

  assign w_ch = {bus.i_ch4, bus.i_ch3, bus.i_ch2, bus.i_ch1};

  // Muted channels are zeroed at capture so the adder never sees them.
  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_mute
      assign w_cap[g] = bus.i_mute[g] ? '0 : w_ch[g];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and control decode; strobes are only accepted in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_add       = 1'b0;
    w_done      = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_sample_stb) begin
          w_capture   = 1'b1;
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        w_add     = 1'b1;
        w_overrun = bus.i_sample_stb;
        if (r_idx == 2'd3) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_overrun   = bus.i_sample_stb;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding register: channel snapshot taken at the accepted strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_hold <= '0;
    else if (w_capture) r_hold <= w_cap;
  end

  // Time-multiplexed adder: one channel per cycle; 4*511 fits in 11 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_capture) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_add) begin
      r_acc <= r_acc + {2'b00, r_hold[r_idx]};
      r_idx <= r_idx + 2'd1;
    end
  end

  // Publish the finished mix and pulse valid for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) r_sample <= r_acc;
    end
  end

  assign w_sd_sum = {1'b0, r_sd} + {1'b0, r_sample};

  // First-order sigma-delta: the accumulator carry is the PDM bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sd  <= '0;
      r_pdm <= 1'b0;
    end else begin
      r_sd  <= w_sd_sum[MIX_W-1:0];
      r_pdm <= w_sd_sum[MIX_W];
    end
  end

  assign bus.o_sample       = r_sample;
  assign bus.o_sample_valid = r_valid;
  assign bus.o_overrun      = w_overrun;
  assign bus.o_pdm          = r_pdm;
endmodule

// File: tb/tb_apu_mixer_dac.sv
// Bench for apu_mixer_dac: table of mix vectors plus hand sequences for
// overrun, input isolation, PDM density and reset mid-mix. A small
// acceptance model pushes expected samples into a scoreboard at the strobe.
module tb_apu_mixer_dac;
  logic clk;
  logic rst_n;

  apu_mixer_dac_if u_if();

  apu_mixer_dac dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  ch1, ch2, ch3, ch4;
    logic [3:0]  mute;
    logic [10:0] exp_s;
  } vec_t;

  typedef struct {
    logic [10:0] val;
    int          cyc;
  } sb_t;

  vec_t        vecs[7];
  sb_t         sbq[$];
  int          total;
  int          bad;
  int          cyc;
  int          busy_end;
  logic [10:0] drv_exp;
  int          ones;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // One clock: model/monitor at the falling edge, then advance past the rise.
  task automatic tick();
    sb_t  e;
    logic exp_ovr;
    @(negedge clk);
    exp_ovr = 1'b0;
    if (rst_n && u_if.i_sample_stb) begin
      if (cyc <= busy_end) exp_ovr = 1'b1;
      else begin
        sbq.push_back('{val: drv_exp, cyc: cyc + 6});
        busy_end = cyc + 5;
      end
    end
    if (u_if.i_sample_stb || u_if.o_overrun)
      chk("overrun", int'(u_if.o_overrun), int'(exp_ovr));
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      chk("missing_valid", 0, 1);
    end
    if (u_if.o_sample_valid) begin
      if (sbq.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("sample", int'(u_if.o_sample), int'(e.val));
        chk("latency", cyc, e.cyc);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_ch(input logic [8:0] c1, c2, c3, c4, input logic [3:0] m);
    u_if.i_ch1  = c1;
    u_if.i_ch2  = c2;
    u_if.i_ch3  = c3;
    u_if.i_ch4  = c4;
    u_if.i_mute = m;
  endtask

  task automatic strobe(input vec_t v);
    set_ch(v.ch1, v.ch2, v.ch3, v.ch4, v.mute);
    drv_exp = v.exp_s;
    u_if.i_sample_stb = 1'b1;
    tick();
    u_if.i_sample_stb = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    chk("drain_pending", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_sample"}, int'(u_if.o_sample), 0);
    chk({nm, "_valid"},  int'(u_if.o_sample_valid), 0);
    chk({nm, "_overrun"}, int'(u_if.o_overrun), 0);
    chk({nm, "_pdm"},    int'(u_if.o_pdm), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{ch1: 9'h1FF, ch2: 9'h100, ch3: 9'h001, ch4: 9'h00B, mute: 4'b0000, exp_s: 11'h30B};
    vecs[1] = '{ch1: 9'h1FF, ch2: 9'h100, ch3: 9'h001, ch4: 9'h00B, mute: 4'b1001, exp_s: 11'h101};
    vecs[2] = '{ch1: 9'h1FF, ch2: 9'h100, ch3: 9'h001, ch4: 9'h00B, mute: 4'b1111, exp_s: 11'd0};
    vecs[3] = '{ch1: 9'h1FF, ch2: 9'h1FF, ch3: 9'h1FF, ch4: 9'h1FF, mute: 4'b0000, exp_s: 11'd2044};
    vecs[4] = '{ch1: 9'h1FF, ch2: 9'h100, ch3: 9'h001, ch4: 9'h00B, mute: 4'b0010, exp_s: 11'd523};
    vecs[5] = '{ch1: 9'h0AA, ch2: 9'h155, ch3: 9'h1FF, ch4: 9'h003, mute: 4'b0100, exp_s: 11'd514};
    vecs[6] = '{ch1: 9'h100, ch2: 9'h100, ch3: 9'h000, ch4: 9'h000, mute: 4'b0000, exp_s: 11'd512};

    total = 0; bad = 0; cyc = 0; busy_end = -100; drv_exp = '0;
    rst_n = 1'b0;
    u_if.i_sample_stb = 1'b0;
    set_ch(9'd0, 9'd0, 9'd0, 9'd0, 4'd0);

    // Reset state.
    repeat (3) tick();
    chk_quiet("in_reset");
    rst_n = 1'b1;
    repeat (2) tick();
    chk_quiet("after_reset");

    // First mix: outputs stay 0 until the valid cycle.
    strobe(vecs[0]);
    for (int i = 1; i <= 5; i++) begin
      chk("pre_valid_sample", int'(u_if.o_sample), 0);
      chk("pre_valid_valid", int'(u_if.o_sample_valid), 0);
      tick();
    end
    drain();
    chk("held_sample", int'(u_if.o_sample), 11'h30B);

    // Table of mute / full-scale vectors.
    for (int i = 1; i < 7; i++) begin
      strobe(vecs[i]);
      drain();
      repeat (2) tick();
      chk("held_after_mix", int'(u_if.o_sample), int'(vecs[i].exp_s));
    end

    // PDM density at o_sample = 512 (left there by the last vector).
    ones = 0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      if (u_if.o_pdm) ones++;
    end
    chk("pdm_density_512", ones, 512);

    // PDM silent at o_sample = 0.
    strobe(vecs[2]);
    drain();
    repeat (2) tick();
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (u_if.o_pdm) ones++;
    end
    chk("pdm_zero", ones, 0);

    // Input isolation: channels change the cycle after the strobe.
    strobe(vecs[0]);
    set_ch(9'd0, 9'd0, 9'd0, 9'd0, 4'b1111);
    drain();

    // Overrun: strobes at cycles 0, 2, 5 -> one mix; cycle 6 is accepted.
    strobe(vecs[3]);
    tick();
    u_if.i_sample_stb = 1'b1; tick(); u_if.i_sample_stb = 1'b0;
    tick(); tick();
    u_if.i_sample_stb = 1'b1; tick(); u_if.i_sample_stb = 1'b0;
    strobe(vecs[0]);
    drain();

    // Reset mid-mix: partial sum discarded, no valid, next mix correct.
    strobe(vecs[3]);
    tick(); tick();
    rst_n = 1'b0;
    sbq.delete();
    busy_end = -100;
    tick();
    rst_n = 1'b1;
    chk("midreset_sample", int'(u_if.o_sample), 0);
    repeat (10) tick();
    chk("midreset_sample_later", int'(u_if.o_sample), 0);
    strobe(vecs[4]);
    drain();
    tick();
    chk("post_reset_mix", int'(u_if.o_sample), 523);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
